// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access controller.
//   - state_e    : controller FSM states
//   - REQ_*      : requester identifiers latched at grant
//   - SEL_*      : address-mux selector codes (3'b111 is never used)
//   - SRC_*      : data address source codes (dt_src)
//   - CAUSE_*    : exception cause codes (exc_cause)
//   - dt_src_sel / exc_cause_sel : map latched codes onto mux selectors
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef logic [1:0] req_id_t;

  localparam req_id_t REQ_IF  = 2'd0;
  localparam req_id_t REQ_DT  = 2'd1;
  localparam req_id_t REQ_EXC = 2'd2;

  localparam logic [2:0] SEL_PC     = 3'b000;
  localparam logic [2:0] SEL_ALUOUT = 3'b001;
  localparam logic [2:0] SEL_REGA   = 3'b010;
  localparam logic [2:0] SEL_REGB   = 3'b011;
  localparam logic [2:0] SEL_EXC253 = 3'b100;
  localparam logic [2:0] SEL_EXC254 = 3'b101;
  localparam logic [2:0] SEL_EXC255 = 3'b110;

  localparam logic [1:0] SRC_ALUOUT = 2'b00;
  localparam logic [1:0] SRC_REGA   = 2'b01;
  localparam logic [1:0] SRC_REGB   = 2'b10;

  localparam logic [1:0] CAUSE_OPCODE   = 2'b00;
  localparam logic [1:0] CAUSE_OVERFLOW = 2'b01;
  localparam logic [1:0] CAUSE_DIVZERO  = 2'b10;

  // Source code 2'b11 falls back to ALUOut.
  function automatic logic [2:0] dt_src_sel(input logic [1:0] src);
    logic [2:0] sel;
    case (src)
      SRC_REGA: sel = SEL_REGA;
      SRC_REGB: sel = SEL_REGB;
      default:  sel = SEL_ALUOUT;
    endcase
    return sel;
  endfunction

  // Causes 2'b10 and 2'b11 both select the divide-by-zero vector.
  function automatic logic [2:0] exc_cause_sel(input logic [1:0] cause);
    logic [2:0] sel;
    case (cause)
      CAUSE_OPCODE:   sel = SEL_EXC253;
      CAUSE_OVERFLOW: sel = SEL_EXC254;
      default:        sel = SEL_EXC255;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Memory latency wait counter.
//   clk      : system clock, rising edge
//   reset    : asynchronous active-low reset (count -> 0)
//   load     : load load_val (takes precedence over dec)
//   load_val : latency to wait, 1..7
//   dec      : decrement by one, holding at zero
//   last     : count is 1, i.e. this is the final wait cycle
module mem_wait_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic       last
);

  logic [2:0] count_q;
  logic [2:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != 3'd0)) begin
      count_d = count_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 3'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == 3'd1);

endmodule

// File: rtl/mem_access_ctrl.sv
// Arbiter and sequencer for the CPU's single memory port.
// Grants one of fetch / data / exception-vector requesters (exc > dt > if), drives the 3-bit
// address-mux selector and write enable, waits MEM_LAT cycles and then pulses the matching done.
//
// Parameters:
//   MEM_LAT    : cycles from address presentation to valid mem_rdata, 1..7
// Ports:
//   clk, reset : clock (rising edge), asynchronous active-low reset
//   if_req     : fetch request (mux 0, PC)
//   dt_req     : data request; dt_we (store) and dt_src (address source) latched at grant
//   exc_req    : exception vector fetch; exc_cause latched at grant
//   mem_rdata  : memory read data
//   mux_sel    : address-mux selector
//   mem_wr     : memory write enable, first ACCESS cycle of a store only
//   if_done, dt_done, exc_done : one-cycle completion pulses
//   exc_vector : {24'b0, mem_rdata[7:0]} captured at exception completion
//   busy       : high in ACCESS and RESP
// Optional feature (macro MEM_ACCESS_CTRL_PERF_EN):
//   acc_cnt    : saturating count of done pulses
//   stall_cnt  : saturating count of cycles with a request waiting
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic        dt_req,
  input  logic        dt_we,
  input  logic [1:0]  dt_src,
  input  logic        exc_req,
  input  logic [1:0]  exc_cause,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  mux_sel,
  output logic        mem_wr,
  output logic        if_done,
  output logic        dt_done,
  output logic        exc_done,
  output logic [31:0] exc_vector,
  output logic        busy
`ifdef MEM_ACCESS_CTRL_PERF_EN
  ,
  output logic [15:0] acc_cnt,
  output logic [15:0] stall_cnt
`endif
);

  localparam logic [2:0] LatInit = 3'(MEM_LAT);

  state_e  state_q;
  req_id_t req_id_q;

  // Arbitration result, only acted on in IDLE.
  logic     grant_valid;
  req_id_t  grant_id;
  logic [2:0] grant_sel;
  logic     grant_wr;
  logic     start;
  logic     cnt_last;

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = REQ_IF;
    grant_sel   = SEL_PC;
    grant_wr    = 1'b0;
    if (exc_req) begin
      grant_valid = 1'b1;
      grant_id    = REQ_EXC;
      grant_sel   = exc_cause_sel(exc_cause);
    end else if (dt_req) begin
      grant_valid = 1'b1;
      grant_id    = REQ_DT;
      grant_sel   = dt_src_sel(dt_src);
      grant_wr    = dt_we;
    end else if (if_req) begin
      grant_valid = 1'b1;
      grant_id    = REQ_IF;
      grant_sel   = SEL_PC;
    end
  end

  assign start = (state_q == IDLE) && grant_valid;

  mem_wait_counter u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (start),
    .load_val (LatInit),
    .dec      (state_q == ACCESS),
    .last     (cnt_last)
  );

  // Only the low byte of the read data forms the handler address.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata[31:8];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_id_q   <= REQ_IF;
      mux_sel    <= SEL_PC;
      mem_wr     <= 1'b0;
      if_done    <= 1'b0;
      dt_done    <= 1'b0;
      exc_done   <= 1'b0;
      exc_vector <= 32'd0;
      busy       <= 1'b0;
    end else begin
      // Write enable and done outputs are single-cycle pulses.
      mem_wr   <= 1'b0;
      if_done  <= 1'b0;
      dt_done  <= 1'b0;
      exc_done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          mux_sel <= SEL_PC;
          busy    <= 1'b0;
          if (start) begin
            state_q  <= ACCESS;
            req_id_q <= grant_id;
            mux_sel  <= grant_sel;
            mem_wr   <= grant_wr;
            busy     <= 1'b1;
          end
        end
        ACCESS: begin
          if (cnt_last) begin
            state_q <= RESP;
            case (req_id_q)
              REQ_EXC: begin
                exc_done   <= 1'b1;
                exc_vector <= {24'd0, mem_rdata[7:0]};
              end
              REQ_DT:  dt_done <= 1'b1;
              default: if_done <= 1'b1;
            endcase
          end
        end
        RESP: begin
          state_q <= IDLE;
          mux_sel <= SEL_PC;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          mux_sel <= SEL_PC;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_ACCESS_CTRL_PERF_EN
  logic any_req;
  logic multi_req;
  logic stall;
  logic any_done;

  assign any_req   = if_req | dt_req | exc_req;
  assign multi_req = (exc_req & (dt_req | if_req)) | (dt_req & if_req);
  // Waiting: the port is occupied, or in IDLE some request lost arbitration.
  assign stall     = any_req && ((state_q != IDLE) || multi_req);
  assign any_done  = if_done | dt_done | exc_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_cnt   <= 16'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (any_done && (acc_cnt != 16'hFFFF)) begin
        acc_cnt <= acc_cnt + 16'd1;
      end
      if (stall && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl. Two instances share all inputs: u_dut1 (MEM_LAT = 1) and
// u_dut3 (MEM_LAT = 3). Outputs are sampled 1 time unit after the rising edge.
module tb_mem_access_ctrl;

  logic        clk;
  logic        reset;
  logic        if_req, dt_req, dt_we, exc_req;
  logic [1:0]  dt_src, exc_cause;
  logic [31:0] mem_rdata;

  logic [2:0]  mux_sel1, mux_sel3;
  logic        mem_wr1, if_done1, dt_done1, exc_done1, busy1;
  logic        mem_wr3, if_done3, dt_done3, exc_done3, busy3;
  logic [31:0] exc_vector1, exc_vector3;
`ifdef MEM_ACCESS_CTRL_PERF_EN
  logic [15:0] acc_cnt1, stall_cnt1, acc_cnt3, stall_cnt3;
`endif

  int checks = 0;
  int failures = 0;

  mem_access_ctrl #(.MEM_LAT(1)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .dt_req     (dt_req),
    .dt_we      (dt_we),
    .dt_src     (dt_src),
    .exc_req    (exc_req),
    .exc_cause  (exc_cause),
    .mem_rdata  (mem_rdata),
    .mux_sel    (mux_sel1),
    .mem_wr     (mem_wr1),
    .if_done    (if_done1),
    .dt_done    (dt_done1),
    .exc_done   (exc_done1),
    .exc_vector (exc_vector1),
    .busy       (busy1)
`ifdef MEM_ACCESS_CTRL_PERF_EN
    ,
    .acc_cnt    (acc_cnt1),
    .stall_cnt  (stall_cnt1)
`endif
  );

  mem_access_ctrl #(.MEM_LAT(3)) u_dut3 (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .dt_req     (dt_req),
    .dt_we      (dt_we),
    .dt_src     (dt_src),
    .exc_req    (exc_req),
    .exc_cause  (exc_cause),
    .mem_rdata  (mem_rdata),
    .mux_sel    (mux_sel3),
    .mem_wr     (mem_wr3),
    .if_done    (if_done3),
    .dt_done    (dt_done3),
    .exc_done   (exc_done3),
    .exc_vector (exc_vector3),
    .busy       (busy3)
`ifdef MEM_ACCESS_CTRL_PERF_EN
    ,
    .acc_cnt    (acc_cnt3),
    .stall_cnt  (stall_cnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b0;
    if_req    = 1'b0;
    dt_req    = 1'b0;
    dt_we     = 1'b0;
    dt_src    = 2'b00;
    exc_req   = 1'b0;
    exc_cause = 2'b00;
    mem_rdata = 32'd0;

    // Reset state
    tick();
    tick();
    chk("rst_mux", {29'd0, mux_sel1}, 32'd0);
    chk("rst_wr", {31'd0, mem_wr1}, 32'd0);
    chk("rst_done", {29'd0, if_done1, dt_done1, exc_done1}, 32'd0);
    chk("rst_vec", exc_vector1, 32'd0);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_busy3", {31'd0, busy3}, 32'd0);

    // 1: fetch, MEM_LAT = 1. This is cycle 0.
    reset  = 1'b1;
    if_req = 1'b1;
    tick();  // cycle 1
    chk("t1_busy_c1", {31'd0, busy1}, 32'd1);
    chk("t1_mux_c1", {29'd0, mux_sel1}, 32'd0);
    chk("t1_wr_c1", {31'd0, mem_wr1}, 32'd0);
    chk("t1_done_c1", {31'd0, if_done1}, 32'd0);
    tick();  // cycle 2
    chk("t1_done_c2", {31'd0, if_done1}, 32'd1);
    chk("t1_wr_c2", {31'd0, mem_wr1}, 32'd0);
    chk("t1_other_done", {30'd0, dt_done1, exc_done1}, 32'd0);
    if_req = 1'b0;
    tick();  // IDLE
    chk("t1_done_off", {31'd0, if_done1}, 32'd0);
    chk("t1_idle_busy", {31'd0, busy1}, 32'd0);

    // 2a: store via reg B
    dt_req = 1'b1;
    dt_we  = 1'b1;
    dt_src = 2'b10;
    tick();
    chk("t2_st_mux", {29'd0, mux_sel1}, 32'd3);
    chk("t2_st_wr", {31'd0, mem_wr1}, 32'd1);
    chk("t2_st_done_early", {31'd0, dt_done1}, 32'd0);
    tick();
    chk("t2_st_wr_off", {31'd0, mem_wr1}, 32'd0);
    chk("t2_st_done", {31'd0, dt_done1}, 32'd1);
    chk("t2_st_mux_resp", {29'd0, mux_sel1}, 32'd3);
    dt_req = 1'b0;
    tick();
    chk("t2_st_done_off", {31'd0, dt_done1}, 32'd0);
    chk("t2_idle_mux", {29'd0, mux_sel1}, 32'd0);

    // 2b: load via reg A
    dt_req = 1'b1;
    dt_we  = 1'b0;
    dt_src = 2'b01;
    tick();
    chk("t2_ld_mux", {29'd0, mux_sel1}, 32'd2);
    chk("t2_ld_wr", {31'd0, mem_wr1}, 32'd0);
    tick();
    chk("t2_ld_wr_resp", {31'd0, mem_wr1}, 32'd0);
    chk("t2_ld_done", {31'd0, dt_done1}, 32'd1);
    dt_req = 1'b0;
    tick();
    chk("t2_ld_idle", {31'd0, busy1}, 32'd0);

    // 3: all three together; exception, then data, then fetch
    if_req    = 1'b1;
    dt_req    = 1'b1;
    dt_we     = 1'b1;
    dt_src    = 2'b11;
    exc_req   = 1'b1;
    exc_cause = 2'b01;
    mem_rdata = 32'h1234_568C;
    tick();
    chk("t3_exc_mux", {29'd0, mux_sel1}, 32'd5);
    chk("t3_exc_wr", {31'd0, mem_wr1}, 32'd0);
    tick();
    chk("t3_exc_done", {29'd0, if_done1, dt_done1, exc_done1}, 32'd1);
    chk("t3_exc_vec", exc_vector1, 32'h0000_008C);
    exc_req   = 1'b0;
    mem_rdata = 32'hFFFF_FF11;
    tick();
    chk("t3_gap1_busy", {31'd0, busy1}, 32'd0);
    chk("t3_gap1_mux", {29'd0, mux_sel1}, 32'd0);
    tick();
    chk("t3_dt_mux", {29'd0, mux_sel1}, 32'd1);
    chk("t3_dt_wr", {31'd0, mem_wr1}, 32'd1);
    tick();
    chk("t3_dt_done", {29'd0, if_done1, dt_done1, exc_done1}, 32'd2);
    dt_req = 1'b0;
    tick();
    chk("t3_gap2_busy", {31'd0, busy1}, 32'd0);
    tick();
    chk("t3_if_busy", {31'd0, busy1}, 32'd1);
    chk("t3_if_mux", {29'd0, mux_sel1}, 32'd0);
    tick();
    chk("t3_if_done", {29'd0, if_done1, dt_done1, exc_done1}, 32'd4);
    chk("t3_vec_hold", exc_vector1, 32'h0000_008C);
    if_req = 1'b0;
    tick();

    // 4: MEM_LAT = 3 exception, cause 11
    reset = 1'b0;
    #1;
    chk("t4_rst_vec3", exc_vector3, 32'd0);
    reset     = 1'b1;
    exc_req   = 1'b1;
    exc_cause = 2'b11;
    mem_rdata = 32'hA5A5_A5F0;
    tick();  // grant edge
    for (int i = 0; i < 3; i++) begin
      chk("t4_mux", {29'd0, mux_sel3}, 32'd6);
      chk("t4_no_done", {31'd0, exc_done3}, 32'd0);
      tick();
    end
    chk("t4_done", {31'd0, exc_done3}, 32'd1);
    chk("t4_vec", exc_vector3, 32'h0000_00F0);
    chk("t4_mux_resp", {29'd0, mux_sel3}, 32'd6);
    exc_req = 1'b0;
    tick();
    chk("t4_done_off", {31'd0, exc_done3}, 32'd0);
    chk("t4_idle", {31'd0, busy3}, 32'd0);

    // 5: reset mid-ACCESS aborts
    dt_req = 1'b1;
    dt_we  = 1'b1;
    dt_src = 2'b00;
    tick();
    chk("t5_wr", {31'd0, mem_wr3}, 32'd1);
    chk("t5_mux", {29'd0, mux_sel3}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_rst_mux", {29'd0, mux_sel3}, 32'd0);
    chk("t5_rst_wr", {31'd0, mem_wr3}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy3}, 32'd0);
    chk("t5_rst_vec", exc_vector3, 32'd0);
    dt_req = 1'b0;
    #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_no_done", {29'd0, if_done3, dt_done3, exc_done3}, 32'd0);
      chk("t5_no_busy", {31'd0, busy3}, 32'd0);
    end

    // 6: inputs change after grant; access completes as granted
    dt_req = 1'b1;
    dt_we  = 1'b0;
    dt_src = 2'b01;
    tick();
    chk("t6_mux_c1", {29'd0, mux_sel3}, 32'd2);
    dt_src = 2'b10;
    dt_req = 1'b0;
    dt_we  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t6_mux_hold", {29'd0, mux_sel3}, 32'd2);
      chk("t6_wr", {31'd0, mem_wr3}, 32'd0);
      chk("t6_no_done", {31'd0, dt_done3}, 32'd0);
    end
    tick();
    chk("t6_done", {31'd0, dt_done3}, 32'd1);
    chk("t6_mux_resp", {29'd0, mux_sel3}, 32'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_single_done", {31'd0, dt_done3}, 32'd0);
      chk("t6_idle", {31'd0, busy3}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequencer and arbiter for the CPU's single memory port and its 3-bit memory-address mux.
- Three requesters share the port: instruction fetch, data load/store and the exception-vector fetch.
- The block grants one requester at a time and drives the address-mux selector and the memory write enable.
- It waits the memory latency, then returns a one-cycle done pulse. For exceptions it also returns the handler address.

Parameters:
MEM_LAT, 1, cycles from address presentation to valid mem_rdata. Legal range 1..7.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; address = PC (mux input 0)
dt_req  in  1  data access request
dt_we  in  1  1 = store, 0 = load; latched at grant
dt_src  in  2  data address source, latched at grant: 00 ALUOut (mux 1), 01 reg A (mux 2), 10 reg B (mux 3), 11 treated as 00
exc_req  in  1  exception vector fetch request
exc_cause  in  2  latched at grant: 00 opcode invalid -> 253 (mux 4), 01 overflow -> 254 (mux 5), 10/11 div-by-zero -> 255 (mux 6)
mem_rdata  in  32  memory read data
mux_sel  out  3  address-mux selector
mem_wr  out  1  memory write enable
if_done  out  1  one-cycle pulse; fetch complete
dt_done  out  1  one-cycle pulse; data access complete
exc_done  out  1  one-cycle pulse; exc_vector valid
exc_vector  out  32  handler PC = {24'b0, mem_rdata[7:0]}, captured at exception completion
busy  out  1  high in ACCESS and RESP

Behaviour:
- States: IDLE, ACCESS, RESP. All outputs are registered.
- Reset (asynchronous, reset = 0): state IDLE, mux_sel 3'b000, mem_wr 0, all done outputs 0, exc_vector 0, busy 0, wait counter 0.
- Abort: reset asserted mid-access aborts the access. No done pulse is produced.
- Grant (IDLE only):
  - Priority is exc_req > dt_req > if_req.
  - On grant, latch the requester ID, dt_we, dt_src and exc_cause.
  - Load the wait counter with MEM_LAT; next state is ACCESS.
  - With no request pending, stay in IDLE and hold mux_sel = 000.
- ACCESS:
  - mux_sel holds the granted selector for the whole state.
  - mem_wr = 1 only in the first ACCESS cycle, and only for a data store.
  - The counter decrements each cycle; at 1, next state is RESP.
- RESP:
  - Exactly one done pulse, matching the granted requester.
  - For an exception, exc_vector is loaded with zero-extended mem_rdata[7:0] on the edge entering RESP.
  - mux_sel keeps its value; next state is IDLE.
- Latency: grant edge t -> done high in cycle t + MEM_LAT + 1. There is a minimum of 1 IDLE cycle between accesses.
- Requester handshake:
  - Requests are level-sensitive; a requester holds req until its done pulse.
  - Deasserting req, or changing dt_we/dt_src/exc_cause, after grant has no effect; the access completes.
- Simultaneous events:
  - An exc_req arriving during a data or fetch access waits; it is served at the next IDLE ahead of pending lower requests.
  - Starvation of if_req is permitted; the control unit guarantees no repeated dt_req.
- Mux code 3'b111 is never driven.

Optional Feature:
MEM_ACCESS_CTRL_PERF_EN:
- Defined: adds output acc_cnt[15:0] and stall_cnt[15:0], both reset to 0 and saturating at 16'hFFFF.
  - acc_cnt increments on every done pulse.
  - stall_cnt increments each cycle that some request is high but not being serviced, i.e. the state is not IDLE, or the request lost arbitration.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_ctrl_pkg holds:
  - the state enum {IDLE, ACCESS, RESP};
  - requester ID constants;
  - mux selector constants SEL_PC = 000, SEL_ALUOUT = 001, SEL_REGA = 010, SEL_REGB = 011, SEL_EXC253 = 100, SEL_EXC254 = 101, SEL_EXC255 = 110;
  - cause code constants.
- One sub-module: mem_wait_counter (load / decrement / last flag, width 3).

Test Plan:
1. MEM_LAT = 1, if_req held from cycle 0 -> mux_sel = 000 in cycle 1, if_done pulses in cycle 2, mem_wr stays 0.
2. dt_req = 1, dt_we = 1, dt_src = 10 -> mux_sel = 011, mem_wr high exactly one cycle, dt_done one cycle later; dt_we = 0 -> mem_wr never asserted.
3. if_req, dt_req and exc_req all rise together, exc_cause = 01, mem_rdata[7:0] = 8'h8C -> exception served first with mux_sel = 101, exc_vector = 32'h0000008C; then data, then fetch, each separated by one IDLE cycle.
4. MEM_LAT = 3, exc_cause = 11 -> mux_sel = 110 for 3 cycles; exc_done arrives 4 cycles after grant.
5. Reset driven low in the middle of ACCESS -> all outputs are immediately at reset values; no done pulse after release.
6. dt_src changed and dt_req dropped one cycle after grant -> the original selector is held and dt_done still pulses once.
